periodic_pattern_gen: RTL and testbench
=======================================

// Module: periodic_pattern_gen
// PURPOSE
//   Parametrised periodic pattern generator: every PERIOD enabled clock cycles
//   the WIDTH-bit output register is updated according to a selectable mode.
//   Modes: invert, rotate-left, increment, hold. The period is run-time
//   programmable and the output register can be seeded. Used as a stimulus
//   source and status-blink driver for the sequential blocks in this design.
// PARAMETERS
//   WIDTH          4   width of pattern output q
//   CNT_W          8   width of the period counter and period register
//   DEFAULT_PERIOD 30  period loaded at reset (must be < 2**CNT_W)
// PORTS
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous, active-low reset
//   en         in   1       count enable; low = counter and q hold
//   period_ld  in   1       load period_in into the period register
//   period_in  in   CNT_W   new period in cycles; 0 is treated as 1
//   seed_ld    in   1       load seed_in into q
//   seed_in    in   WIDTH   seed value
//   mode       in   2       00 invert, 01 rotate-left, 10 increment, 11 hold
//   q          out  WIDTH   pattern register
//   tick       out  1       one-cycle pulse, high in the cycle q takes an update
//   cnt        out  CNT_W   current counter value (debug/observe)
// BEHAVIOUR
//   - Reset (rst==0, async): q=0, cnt=0, period_reg=DEFAULT_PERIOD, tick=0.
//   - eff_period = (period_reg==0) ? 1 : period_reg.
//   - Each posedge, priority high->low:
//     1. period_ld or seed_ld: period_reg<=period_in (if period_ld),
//        q<=seed_in (if seed_ld), cnt<=0, tick<=0. Both may assert together;
//        both take effect. No pattern update that cycle, regardless of en.
//     2. en==0: cnt, q hold; tick<=0.
//     3. en==1 and cnt==eff_period-1: q<=next(q,mode), cnt<=0, tick<=1.
//     4. en==1 otherwise: cnt<=cnt+1, tick<=0.
//   - Update period: exactly eff_period enabled cycles between q updates;
//     first update occurs on the eff_period-th enabled edge after reset/load.
//   - next(): invert = ~q; rotate-left = {q[WIDTH-2:0],q[WIDTH-1]};
//     increment = q+1 modulo 2**WIDTH (wraps all-ones -> 0); hold = q
//     (tick still pulses in hold mode).
//   - mode is sampled on the update edge only; changing mode mid-period is
//     legal and affects only the next update.
//   - Lowering en mid-period freezes cnt; count resumes from the frozen value.
//   - cnt never exceeds eff_period-1 except transiently when period_reg is
//     reprogrammed, which is impossible since every load clears cnt.
//   - Reset asserted mid-period aborts immediately; no tick is produced.
//   - tick and q are registered; no combinational path input->output.
//   - WIDTH==1: rotate-left degenerates to hold; must still elaborate.
// STRUCTURE
//   - Package pattern_gen_pkg: mode localparams MODE_INV=2'b00,
//     MODE_ROL=2'b01, MODE_INC=2'b10, MODE_HOLD=2'b11.
//   - Sub-module period_counter (clk, rst, en, clr, period, cnt, wrap):
//     holds the CNT_W counter and zero-as-one handling; wrap is combinational
//     en && cnt==eff_period-1. Top holds period_reg, q, tick and next().
// TESTING
//   1. Reset, en=1, mode=00, 65 cycles -> q 0000->1111 at cycle 30,
//      ->0000 at cycle 60; tick high exactly on those two cycles.
//   2. seed_ld seed_in=0001, mode=01, period_ld period_in=3 -> q rotates
//      0001,0010,0100,1000,0001 every 3 cycles; tick every 3rd cycle.
//   3. mode=10, period_in=0, seed 1110 -> q=1111 next enabled cycle, then
//      0000 (wrap); tick high every cycle.
//   4. period 5, en dropped for 7 cycles after cnt=2 -> cnt holds 2, update
//      occurs 3 enabled cycles after en returns; no tick while en=0.
//   5. period_ld and seed_ld asserted together on a would-be wrap cycle ->
//      q=seed_in, cnt=0, tick=0; next update after new period.
//   6. rst pulsed low asynchronously mid-period (cnt=17) -> q=0, cnt=0,
//      tick=0 immediately; period_reg back to 30.

Source files
------------

// File: rtl/periodic_pattern_gen_pkg.sv
// Shared definitions for the periodic pattern generator: pattern update modes.
package pattern_gen_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_INV  = 2'b00;
  localparam mode_t MODE_ROL  = 2'b01;
  localparam mode_t MODE_INC  = 2'b10;
  localparam mode_t MODE_HOLD = 2'b11;

endpackage

// File: rtl/periodic_pattern_gen_if.sv
// Control/observe bundle of the pattern generator; master drives controls, slave is the generator.
interface periodic_pattern_gen_if
  import pattern_gen_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) ();

  logic             en;
  logic             period_ld;
  logic [CNT_W-1:0] period_in;
  logic             seed_ld;
  logic [WIDTH-1:0] seed_in;
  mode_t            mode;
  logic [WIDTH-1:0] q;
  logic             tick;
  logic [CNT_W-1:0] cnt;

  modport master (
    output en, period_ld, period_in, seed_ld, seed_in, mode,
    input  q, tick, cnt
  );

  modport slave (
    input  en, period_ld, period_in, seed_ld, seed_in, mode,
    output q, tick, cnt
  );

endinterface

// File: rtl/periodic_pattern_gen_counter.sv
// Period counter: counts enabled cycles and flags the last cycle of each period.
module period_counter
  import pattern_gen_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] eff_period;

  // A programmed period of zero behaves as a period of one.
  assign eff_period = (period == '0) ? CNT_W'(1) : period;
  assign wrap       = en && (cnt_q == eff_period - CNT_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (wrap) cnt_d = '0;
    else if (en)   cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/periodic_pattern_gen.sv
// Periodic pattern generator: updates q by the selected mode once every programmed period.
module periodic_pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int CNT_W          = 8,
  parameter int DEFAULT_PERIOD = 30
) (
  input logic                  clk,
  input logic                  rst,
  periodic_pattern_gen_if.slave bus
);

  logic [CNT_W-1:0] period_q, period_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic             load;

  // Rotation built bitwise so that WIDTH==1 collapses cleanly to hold.
  function automatic logic [WIDTH-1:0] next_pattern(input logic [WIDTH-1:0] cur, input mode_t m);
    logic [WIDTH-1:0] rol;
    logic [WIDTH-1:0] res;
    for (int i = 0; i < WIDTH; i++) rol[(i + 1) % WIDTH] = cur[i];
    case (m)
      MODE_INV: res = ~cur;
      MODE_ROL: res = rol;
      MODE_INC: res = cur + WIDTH'(1);
      default:  res = cur;
    endcase
    return res;
  endfunction

  assign load = bus.period_ld | bus.seed_ld;

  period_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .en     (bus.en),
    .clr    (load),
    .period (period_q),
    .cnt    (cnt),
    .wrap   (wrap)
  );

  // Loads take precedence and suppress any pattern update in the same cycle.
  always_comb begin
    period_d = period_q;
    q_d      = q_q;
    tick_d   = 1'b0;
    if (load) begin
      if (bus.period_ld) period_d = bus.period_in;
      if (bus.seed_ld)   q_d      = bus.seed_in;
    end else if (wrap) begin
      q_d    = next_pattern(q_q, bus.mode);
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_q <= CNT_W'(DEFAULT_PERIOD);
      q_q      <= '0;
      tick_q   <= 1'b0;
    end else begin
      period_q <= period_d;
      q_q      <= q_d;
      tick_q   <= tick_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.tick = tick_q;
  assign bus.cnt  = cnt;

endmodule

// File: tb/tb_periodic_pattern_gen.sv
// Self-checking bench for periodic_pattern_gen: directed scenarios plus randomized run against a reference model.
module tb_periodic_pattern_gen;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state: pattern, enabled cycles since last update/load, period, tick.
  int m_q, m_elapsed, m_period, m_tick;

  periodic_pattern_gen_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  periodic_pattern_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W), .DEFAULT_PERIOD(30)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int ref_next(int v, int m);
    case (m)
      0:       return 15 - v;
      1:       return ((v * 2) % 16) + (v / 8);
      2:       return (v + 1) % 16;
      default: return v;
    endcase
  endfunction

  task automatic idle_inputs();
    bus.en = 1'b0; bus.period_ld = 1'b0; bus.period_in = '0;
    bus.seed_ld = 1'b0; bus.seed_in = '0; bus.mode = 2'b00;
  endtask

  // Advance one clock; the model consumes the inputs that are applied at this edge.
  task automatic step();
    int eff;
    if (bus.period_ld || bus.seed_ld) begin
      if (bus.period_ld) m_period = int'(bus.period_in);
      if (bus.seed_ld)   m_q = int'(bus.seed_in);
      m_elapsed = 0;
      m_tick = 0;
    end else if (!bus.en) begin
      m_tick = 0;
    end else begin
      eff = (m_period == 0) ? 1 : m_period;
      m_elapsed++;
      if (m_elapsed == eff) begin
        m_q = ref_next(m_q, int'(bus.mode));
        m_elapsed = 0;
        m_tick = 1;
      end else begin
        m_tick = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    m_q = 0; m_elapsed = 0; m_period = 30; m_tick = 0;
  endtask

  task automatic load(input logic pld, input int per, input logic sld, input int seed, input int md);
    bus.period_ld = pld; bus.period_in = CNT_W'(per);
    bus.seed_ld = sld;   bus.seed_in = WIDTH'(seed);
    bus.mode = 2'(md);
    step();
    bus.period_ld = 1'b0; bus.seed_ld = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.q !== 4'h0 || bus.cnt !== 8'd0 || bus.tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: q=%h cnt=%0d tick=%b required q=0 cnt=0 tick=0", bus.q, bus.cnt, bus.tick);
    end
  endtask

  task automatic test_invert_default_period();
    logic [3:0] eq;
    do_reset();
    bus.en = 1'b1; bus.mode = 2'b00;
    for (int i = 1; i <= 65; i++) begin
      step();
      eq = (i >= 30 && i < 60) ? 4'hF : 4'h0;
      checks++;
      if (bus.tick !== ((i == 30) || (i == 60)) || bus.q !== eq) begin
        errors++;
        $display("FAIL invert_default cyc%0d: q=%h tick=%b required q=%h tick=%b", i, bus.q, bus.tick, eq, (i == 30) || (i == 60));
      end
    end
  endtask

  task automatic test_rotate();
    logic [3:0] seq [5];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
    do_reset();
    bus.en = 1'b1;
    load(1'b1, 3, 1'b1, 1, 1);
    for (int i = 1; i <= 12; i++) begin
      step();
      checks++;
      if (bus.q !== seq[i / 3] || bus.tick !== (i % 3 == 0)) begin
        errors++;
        $display("FAIL rotate cyc%0d: q=%b tick=%b required q=%b tick=%b", i, bus.q, bus.tick, seq[i / 3], i % 3 == 0);
      end
    end
  endtask

  task automatic test_increment_zero_period();
    logic [3:0] eq;
    do_reset();
    bus.en = 1'b1;
    load(1'b1, 0, 1'b1, 14, 2);
    for (int i = 1; i <= 4; i++) begin
      step();
      eq = 4'((14 + i) % 16);
      checks++;
      if (bus.q !== eq || bus.tick !== 1'b1 || bus.cnt !== 8'd0) begin
        errors++;
        $display("FAIL inc_zero_period cyc%0d: q=%h tick=%b cnt=%0d required q=%h tick=1 cnt=0", i, bus.q, bus.tick, bus.cnt, eq);
      end
    end
  endtask

  task automatic test_enable_freeze();
    logic [3:0] q0;
    do_reset();
    bus.en = 1'b1;
    load(1'b1, 5, 1'b1, 6, 0);
    step(); step();
    q0 = bus.q;
    bus.en = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      checks++;
      if (bus.cnt !== 8'd2 || bus.tick !== 1'b0 || bus.q !== q0) begin
        errors++;
        $display("FAIL en_freeze cyc%0d: cnt=%0d tick=%b q=%h required cnt=2 tick=0 q=%h", i, bus.cnt, bus.tick, bus.q, q0);
      end
    end
    bus.en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (bus.tick !== (i == 3) || bus.q !== ((i == 3) ? ~q0 : q0)) begin
        errors++;
        $display("FAIL en_resume cyc%0d: tick=%b q=%h required tick=%b q=%h", i, bus.tick, bus.q, i == 3, (i == 3) ? ~q0 : q0);
      end
    end
  endtask

  task automatic test_load_on_wrap();
    do_reset();
    bus.en = 1'b1;
    load(1'b1, 4, 1'b0, 0, 2);
    step(); step(); step();
    load(1'b1, 2, 1'b1, 9, 2);
    checks++;
    if (bus.q !== 4'd9 || bus.cnt !== 8'd0 || bus.tick !== 1'b0) begin
      errors++;
      $display("FAIL load_on_wrap: q=%h cnt=%0d tick=%b required q=9 cnt=0 tick=0", bus.q, bus.cnt, bus.tick);
    end
    for (int i = 1; i <= 2; i++) begin
      step();
      checks++;
      if (bus.tick !== (i == 2) || bus.q !== ((i == 2) ? 4'd10 : 4'd9)) begin
        errors++;
        $display("FAIL after_load cyc%0d: tick=%b q=%h required tick=%b q=%h", i, bus.tick, bus.q, i == 2, (i == 2) ? 4'd10 : 4'd9);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.en = 1'b1;
    load(1'b1, 0, 1'b1, 5, 0);
    for (int i = 0; i < 3; i++) step();
    load(1'b1, 40, 1'b0, 0, 0);
    for (int i = 0; i < 17; i++) step();
    checks++;
    if (bus.cnt !== 8'd17) begin
      errors++;
      $display("FAIL pre_reset_cnt: cnt=%0d required 17", bus.cnt);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.q !== 4'h0 || bus.cnt !== 8'd0 || bus.tick !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: q=%h cnt=%0d tick=%b required q=0 cnt=0 tick=0", bus.q, bus.cnt, bus.tick);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    m_q = 0; m_elapsed = 0; m_period = 30; m_tick = 0;
    for (int i = 1; i <= 31; i++) begin
      step();
      checks++;
      if (bus.tick !== (i == 30)) begin
        errors++;
        $display("FAIL reset_period cyc%0d: tick=%b required %b", i, bus.tick, i == 30);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.en        = ($urandom_range(0, 3) != 0);
      bus.period_ld = ($urandom_range(0, 15) == 0);
      bus.period_in = CNT_W'($urandom_range(0, 6));
      bus.seed_ld   = ($urandom_range(0, 15) == 0);
      bus.seed_in   = WIDTH'($urandom_range(0, 15));
      bus.mode      = 2'($urandom_range(0, 3));
      step();
      checks++;
      if (bus.q !== 4'(m_q) || bus.cnt !== 8'(m_elapsed) || bus.tick !== 1'(m_tick)) begin
        errors++;
        $display("FAIL random cyc%0d: q=%h cnt=%0d tick=%b required q=%h cnt=%0d tick=%0d",
                 i, bus.q, bus.cnt, bus.tick, 4'(m_q), m_elapsed, m_tick);
      end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_invert_default_period();
    test_rotate();
    test_increment_zero_period();
    test_enable_freeze();
    test_load_on_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
